// File: rtl/fix_seq_table.sv
// Per-host FIX sequence-number table: outgoing/incoming counters with gap/low
// detection and a double-dabble binary-to-ASCII converter for outgoing numbers.
module fix_seq_table #(
  parameter int HOST_W = 4,
  parameter int SEQ_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_valid_i,
  input  logic [1:0]                   op_code_i,
  input  logic [HOST_W-1:0]            op_host_i,
  input  logic [SEQ_W-1:0]             op_seq_i,
  output logic                         op_ready_o,
  output logic                         done_o,
  output logic [1:0]                   result_o,
  output logic [SEQ_W-1:0]             seq_o,
  output logic [8*DIGITS-1:0]          ascii_o,
  output logic [$clog2(DIGITS+1)-1:0]  ascii_size_o,
  output logic                         wrap_o
);

  localparam int HOSTS  = 1 << HOST_W;
  localparam int SIZE_W = $clog2(DIGITS + 1);
  localparam int CNT_W  = $clog2(SEQ_W + 1);
  localparam int BCD_W  = 4 * DIGITS;

  localparam logic [1:0] OP_NEXT_OUT   = 2'b00;
  localparam logic [1:0] OP_CHECK_IN   = 2'b01;
  localparam logic [1:0] OP_RESET_HOST = 2'b10;
  localparam logic [1:0] OP_SET_IN     = 2'b11;
  localparam logic [1:0] RES_OK        = 2'b00;
  localparam logic [1:0] RES_GAP       = 2'b01;
  localparam logic [1:0] RES_LOW       = 2'b10;

  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);
  localparam logic [SEQ_W-1:0] SEQ_MAX = '1;

  localparam real P10  = 10.0 ** DIGITS;
  localparam real SMAX = (2.0 ** SEQ_W) - 1.0;

  generate
    if (P10 <= SMAX) begin : g_bad_digits
      $error("fix_seq_table: DIGITS too small to represent every SEQ_W value");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            code_r;
  logic [HOST_W-1:0]     host_r;
  logic [SEQ_W-1:0]      seq_in_r;
  logic [SEQ_W-1:0]      out_tab [HOSTS];
  logic [SEQ_W-1:0]      in_tab  [HOSTS];
  logic [SEQ_W-1:0]      bin_r;
  logic [BCD_W-1:0]      bcd_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [BCD_W-1:0]      bcd_nxt;
  logic [SIZE_W-1:0]     size_nxt;
  logic                  conv_last;
  logic [SEQ_W-1:0]      set_val;

  // Counters never hold 0: wrapping skips straight from all-ones to 1.
  function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] v);
    return (v == SEQ_MAX) ? SEQ_ONE : v + SEQ_ONE;
  endfunction

  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                               input logic b);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int k = 0; k < DIGITS; k++)
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    return {adj[BCD_W-2:0], b};
  endfunction

  function automatic logic [SIZE_W-1:0] size_of(input logic [BCD_W-1:0] bcd);
    logic [SIZE_W-1:0] s;
    s = SIZE_W'(1);
    for (int k = 0; k < DIGITS; k++)
      if (bcd[4*k +: 4] != 4'd0) s = SIZE_W'(k + 1);
    return s;
  endfunction

  function automatic logic [8*DIGITS-1:0] ascii_of(input logic [BCD_W-1:0] bcd,
                                                   input logic [SIZE_W-1:0] size);
    logic [8*DIGITS-1:0] a;
    a = '0;
    for (int k = 0; k < DIGITS; k++)
      if (k < int'(size)) a[8*k +: 8] = {4'h3, bcd[4*k +: 4]};
    return a;
  endfunction

  assign bcd_nxt   = dd_step(bcd_r, bin_r[SEQ_W-1]);
  assign size_nxt  = size_of(bcd_nxt);
  assign conv_last = (cnt_r == CNT_W'(SEQ_W - 1));
  assign set_val   = (seq_in_r == '0) ? SEQ_ONE : seq_in_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_valid_i) state_nxt = EXEC;
      EXEC:    state_nxt = (code_r == OP_NEXT_OUT) ? CONV : DONE;
      CONV:    if (conv_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_ready_o = (state == IDLE);
    done_o     = (state == DONE);
  end

  // Result registers only change on the edge entering DONE, so they hold
  // steady across the following idle/execute period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_r       <= '0;
      host_r       <= '0;
      seq_in_r     <= '0;
      bin_r        <= '0;
      bcd_r        <= '0;
      cnt_r        <= '0;
      result_o     <= RES_OK;
      seq_o        <= '0;
      ascii_o      <= '0;
      ascii_size_o <= '0;
      wrap_o       <= 1'b0;
      for (int h = 0; h < HOSTS; h++) begin
        out_tab[h] <= SEQ_ONE;
        in_tab[h]  <= SEQ_ONE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (op_valid_i) begin
            code_r   <= op_code_i;
            host_r   <= op_host_i;
            seq_in_r <= op_seq_i;
          end
        end
        EXEC: begin
          cnt_r <= '0;
          bin_r <= out_tab[host_r];
          bcd_r <= '0;
          if (code_r != OP_NEXT_OUT) begin
            ascii_o      <= '0;
            ascii_size_o <= '0;
            wrap_o       <= 1'b0;
          end
          case (code_r)
            OP_CHECK_IN: begin
              seq_o <= in_tab[host_r];
              if (seq_in_r == '0 || seq_in_r < in_tab[host_r]) begin
                result_o <= RES_LOW;
              end else if (seq_in_r > in_tab[host_r]) begin
                result_o <= RES_GAP;
              end else begin
                result_o       <= RES_OK;
                in_tab[host_r] <= seq_inc(in_tab[host_r]);
              end
            end
            OP_RESET_HOST: begin
              seq_o           <= SEQ_ONE;
              result_o        <= RES_OK;
              out_tab[host_r] <= SEQ_ONE;
              in_tab[host_r]  <= SEQ_ONE;
            end
            OP_SET_IN: begin
              seq_o          <= set_val;
              result_o       <= RES_OK;
              in_tab[host_r] <= set_val;
            end
            default: ;
          endcase
        end
        CONV: begin
          bcd_r <= bcd_nxt;
          bin_r <= bin_r << 1;
          cnt_r <= cnt_r + CNT_W'(1);
          if (conv_last) begin
            seq_o           <= out_tab[host_r];
            result_o        <= RES_OK;
            ascii_o         <= ascii_of(bcd_nxt, size_nxt);
            ascii_size_o    <= size_nxt;
            wrap_o          <= (out_tab[host_r] == SEQ_MAX);
            out_tab[host_r] <= seq_inc(out_tab[host_r]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_seq_table.sv
// Directed bench for fix_seq_table: a 32-bit instance for the main flows and a
// 4-bit instance to reach the counter wrap and multi-digit ASCII quickly.
module tb_fix_seq_table;

  localparam logic [1:0] NEXT = 2'b00, CHK = 2'b01, RSTH = 2'b10, SETI = 2'b11;
  localparam logic [1:0] OK = 2'b00, GAP = 2'b01, LOW = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        op_valid = 1'b0;
  logic [1:0]  op_code  = '0;
  logic [3:0]  op_host  = '0;
  logic [31:0] op_seq   = '0;
  logic        op_ready, done;
  logic [1:0]  result;
  logic [31:0] seq_o;
  logic [79:0] ascii;
  logic [3:0]  ascii_size;
  logic        wrap;

  logic        s_valid = 1'b0;
  logic [1:0]  s_code  = '0;
  logic        s_host  = 1'b0;
  logic [3:0]  s_seq   = '0;
  logic        s_ready, s_done;
  logic [1:0]  s_result;
  logic [3:0]  s_seqo;
  logic [15:0] s_ascii;
  logic [1:0]  s_size;
  logic        s_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] r_seq;
  logic [1:0]  r_res;
  logic [79:0] r_ascii;
  logic [3:0]  r_size;
  logic        r_wrap;
  int          r_lat;

  fix_seq_table #(.HOST_W(4), .SEQ_W(32), .DIGITS(10)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_code_i(op_code),
    .op_host_i(op_host), .op_seq_i(op_seq), .op_ready_o(op_ready),
    .done_o(done), .result_o(result), .seq_o(seq_o), .ascii_o(ascii),
    .ascii_size_o(ascii_size), .wrap_o(wrap)
  );

  fix_seq_table #(.HOST_W(1), .SEQ_W(4), .DIGITS(2)) u_small (
    .clk(clk), .rst(rst), .op_valid_i(s_valid), .op_code_i(s_code),
    .op_host_i(s_host), .op_seq_i(s_seq), .op_ready_o(s_ready),
    .done_o(s_done), .result_o(s_result), .seq_o(s_seqo), .ascii_o(s_ascii),
    .ascii_size_o(s_size), .wrap_o(s_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation (called after a falling edge with the DUT idle) and
  // capture the outputs in the done cycle; r_lat counts falling edges from
  // the acceptance edge to the first one with done high.
  task automatic run_op(input bit sm, input logic [1:0] code, input int host,
                        input logic [31:0] seq);
    logic [31:0] h;
    h = host;
    if (sm) begin
      s_valid = 1'b1; s_code = code; s_host = h[0]; s_seq = seq[3:0];
    end else begin
      op_valid = 1'b1; op_code = code; op_host = h[3:0]; op_seq = seq;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    op_valid = 1'b0;
    r_lat = 0;
    while (r_lat < 200) begin
      @(negedge clk);
      r_lat++;
      if (sm ? s_done : done) break;
    end
    if (!(sm ? s_done : done)) check("done_timeout", 80'd0, 80'd1);
    r_seq   = sm ? {28'd0, s_seqo} : seq_o;
    r_res   = sm ? s_result : result;
    r_ascii = sm ? {64'd0, s_ascii} : ascii;
    r_size  = sm ? {2'd0, s_size} : ascii_size;
    r_wrap  = sm ? s_wrap : wrap;
    @(negedge clk);
  endtask

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    check("rst_ready", op_ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_seq", seq_o, 0);
    check("rst_ascii", ascii, 0);
    check("rst_size", ascii_size, 0);
    check("rst_wrap", wrap, 0);
    rst = 1'b1;

    // Three NEXT_OUTs on host 3, the first on the first edge after release
    for (int i = 1; i <= 3; i++) begin
      run_op(0, NEXT, 3, 0);
      check("next_seq", r_seq, i);
      check("next_ascii", r_ascii, 80'h30 + i);
      check("next_size", r_size, 1);
      check("next_lat", r_lat, 34);
      check("next_wrap", r_wrap, 0);
      check("next_res", r_res, OK);
    end

    // Gap, in-order, duplicate and zero on host 1
    run_op(0, CHK, 1, 7);
    check("gap_res", r_res, GAP);
    check("gap_seq", r_seq, 1);
    check("chk_lat", r_lat, 2);
    check("chk_ascii", r_ascii, 0);
    check("chk_size", r_size, 0);
    run_op(0, CHK, 1, 1);
    check("inorder_res", r_res, OK);
    check("inorder_seq", r_seq, 1);
    run_op(0, CHK, 1, 1);
    check("dup_res", r_res, LOW);
    check("dup_seq", r_seq, 2);
    run_op(0, CHK, 1, 0);
    check("zero_res", r_res, LOW);

    // SET_IN then matching and repeated CHECK_IN on host 2
    run_op(0, SETI, 2, 32'd1234567890);
    check("setin_res", r_res, OK);
    check("setin_seq", r_seq, 32'd1234567890);
    check("setin_lat", r_lat, 2);
    run_op(0, CHK, 2, 32'd1234567890);
    check("setchk_res", r_res, OK);
    check("setchk_seq", r_seq, 32'd1234567890);
    run_op(0, CHK, 2, 32'd1234567890);
    check("setchk2_res", r_res, LOW);
    check("setchk2_seq", r_seq, 32'd1234567891);
    run_op(0, SETI, 6, 0);
    check("setin0_seq", r_seq, 1);
    run_op(0, CHK, 6, 1);
    check("setin0_chk", r_res, OK);

    // RESET_HOST on host 3 restarts its outgoing counter only there
    run_op(0, RSTH, 3, 0);
    check("rsth_seq", r_seq, 1);
    check("rsth_res", r_res, OK);
    run_op(0, NEXT, 3, 0);
    check("rsth_next", r_seq, 1);
    run_op(0, CHK, 2, 32'd1234567891);
    check("other_host_kept", r_res, OK);

    // Small instance: multi-digit ASCII, wrap to 1, and untouched host 1
    for (int i = 1; i <= 15; i++) begin
      run_op(1, NEXT, 0, 0);
      check("s_seq", r_seq, i);
      if (i == 9) begin
        check("s9_ascii", r_ascii, 80'h39);
        check("s9_size", r_size, 1);
        check("s_lat", r_lat, 6);
      end
      if (i == 10) begin
        check("s10_ascii", r_ascii, 80'h3130);
        check("s10_size", r_size, 2);
      end
      if (i == 14) check("s14_wrap", r_wrap, 0);
      if (i == 15) begin
        check("s15_ascii", r_ascii, 80'h3135);
        check("s15_size", r_size, 2);
        check("s15_wrap", r_wrap, 1);
      end
    end
    run_op(1, NEXT, 0, 0);
    check("s_after_wrap", r_seq, 1);
    check("s_after_wrap_w", r_wrap, 0);
    run_op(1, NEXT, 1, 0);
    check("s_host1", r_seq, 1);

    // Abort a NEXT_OUT on host 4 with reset ten cycles in
    op_valid = 1'b1; op_code = NEXT; op_host = 4'd4;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", op_ready, 1);
    check("abort_seq_clr", seq_o, 0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(0, NEXT, 4, 0);
    check("abort_next", r_seq, 1);

    // Request held high with another host during conversion is ignored
    op_valid = 1'b1; op_code = NEXT; op_host = 4'd7;
    @(posedge clk);
    #1 op_host = 4'd8;
    ndone = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        op_valid = 1'b0;
        break;
      end
    end
    op_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("hold_one_done", ndone, 1);
    check("hold_seq", seq_o, 1);
    run_op(0, NEXT, 8, 0);
    check("hold_host8", r_seq, 1);
    run_op(0, NEXT, 7, 0);
    check("hold_host7", r_seq, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
